smoke_req_engine: RTL

- Request-processing target that sits directly downstream of smoke_bfm in the smoke testbench.
- The BFM issues opcode/data requests over a valid/ready channel. The block executes each request against an accumulator and a transaction counter.
- Results are buffered in a response FIFO and returned over a second valid/ready channel to the BFM.
- Gives the RPC smoke test real handshakes, back-pressure and ordering to exercise.

---
 rtl/smoke_pkg.sv | 20 ++
 rtl/smoke_rsp_fifo.sv | 76 +++++++
 rtl/smoke_req_engine.sv | 121 ++++++++++++
 3 files changed

// File: rtl/smoke_pkg.sv
// Shared types for the smoke request engine.
//   smoke_op_e  : request opcode carried on req_op.
//   smoke_rsp_s : response payload {ovf, data} at the default data width.
package smoke_pkg;

    localparam int unsigned SMOKE_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_ADD   = 2'd1,
        OP_READ  = 2'd2,
        OP_COUNT = 2'd3
    } smoke_op_e;

    typedef struct packed {
        logic                    ovf;
        logic [SMOKE_DATA_W-1:0] data;
    } smoke_rsp_s;

endpackage

// File: rtl/smoke_rsp_fifo.sv
// Response FIFO: register array storage, async-reset pointers and occupancy.
//   clock, reset_n : clock and asynchronous active-low reset
//   push/push_data : write an entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   head_data      : current head entry
//   empty/full     : occupancy flags
//   count          : occupancy, log2(DEPTH)+1 bits
module smoke_rsp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign count     = cnt_q;
    assign head_data = mem_q[rd_q];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer / occupancy next state; pointers wrap naturally at power-of-two depth.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; consumers gate the head with empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data;
        end
    end

endmodule

// File: rtl/smoke_req_engine.sv
// Single-cycle request engine: executes WRITE/ADD/READ/COUNT against an
// accumulator and a request counter, queuing one response per request.
//   clock, reset_n          : clock and asynchronous active-low reset
//   req_valid/req_ready     : request handshake; req_op, req_data payload
//   rsp_valid/rsp_ready     : response handshake; rsp_data, rsp_ovf payload
//   busy                    : response FIFO non-empty
module smoke_req_engine
    import smoke_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ovf,
    output logic              busy
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam int unsigned RSP_W = DATA_W + 1;

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] rsp_dat_d;
    logic              rsp_ovf_d;
    logic              push, pop;
    logic [RSP_W-1:0]  head;
    logic              empty, full;
    logic [OCC_W-1:0]  occ, occ_nxt;

    assign push = req_valid & rdy_q & ~full;
    assign pop  = ~empty & rsp_ready;
    assign sum  = {1'b0, acc_q} + {1'b0, req_data};

    // Op execution in the accept cycle.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        rsp_dat_d = '0;
        rsp_ovf_d = 1'b0;
        if (push) begin
            cnt_d = cnt_q + CNT_W'(1);
            case (smoke_op_e'(req_op))
                OP_WRITE: begin
                    acc_d     = req_data;
                    rsp_dat_d = req_data;
                end
                OP_ADD: begin
                    acc_d     = sum[DATA_W-1:0];
                    rsp_dat_d = sum[DATA_W-1:0];
                    rsp_ovf_d = sum[DATA_W];
                end
                OP_READ: begin
                    rsp_dat_d = acc_q;
                end
                OP_COUNT: begin
                    rsp_dat_d = DATA_W'(cnt_d);
                end
                default: begin
                    rsp_dat_d = '0;
                end
            endcase
        end
    end

    // Ready for next cycle comes from next occupancy only, never from rsp_ready directly.
    always_comb begin
        occ_nxt = occ;
        if (push && !pop) begin
            occ_nxt = occ + OCC_W'(1);
        end else if (!push && pop) begin
            occ_nxt = occ - OCC_W'(1);
        end
        rdy_d = (occ_nxt != OCC_W'(DEPTH));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end

    smoke_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({rsp_ovf_d, rsp_dat_d}),
        .pop       (pop),
        .head_data (head),
        .empty     (empty),
        .full      (full),
        .count     (occ)
    );

    // Head is masked while empty so the payload reads zero out of reset.
    assign req_ready = rdy_q;
    assign rsp_valid = ~empty;
    assign busy      = ~empty;
    assign rsp_data  = empty ? '0 : head[DATA_W-1:0];
    assign rsp_ovf   = ~empty & head[DATA_W];

endmodule
